// File: rtl/mips_ifu.sv
// Instruction fetch unit for the single-cycle MIPS-Lite4 datapath.
// The PC register, a writable instruction memory with a combinational fetch,
// field slicing for the decoder, next-PC selection, a retired-instruction
// counter and sticky fault flags.
module mips_ifu #(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        nPC_sel,
  input  logic              zero,
  input  logic [31:0]       rs_data,
  input  logic              im_we,
  input  logic [ADDR_W-1:0] im_waddr,
  input  logic [31:0]       im_wdata,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              fetch_err,
  output logic              align_err,
  output logic [31:0]       instr_count
);

  // Instruction store; the loader port writes it, the PC reads it asynchronously.
  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        fetch_err_q, fetch_err_d;
  logic        align_err_q, align_err_d;

  logic [31:0]       pc_off;
  logic              in_win;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       br_off;

  // Window test: offset from the base must fit in ADDR_W word-address bits.
  // PC is always word aligned (all next-PC sources are), so bits [1:0] are zero.
  assign pc_off = pc_q - PC_BASE;
  assign in_win = ((pc_off >> (ADDR_W + 2)) == 32'd0);
  assign widx   = pc_off[ADDR_W+1:2];

  // Out-of-window fetches return a nop rather than aliasing into the memory.
  assign instr    = in_win ? mem_q[widx] : 32'h0000_0000;
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign func     = instr[5:0];
  assign imm16    = instr[15:0];

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_err   = fetch_err_q;
  assign align_err   = align_err_q;
  assign instr_count = instr_count_q;

  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Loader write port; deliberately unaffected by reset and stall.
  always_ff @(posedge clk) begin
    if (im_we) begin
      mem_q[im_waddr] <= im_wdata;
    end
  end

  // Next-PC selection, counter increment and fault detection for an active cycle.
  always_comb begin
    pc_d          = pc_q;
    instr_count_d = instr_count_q;
    fetch_err_d   = fetch_err_q;
    align_err_d   = align_err_q;
    if (!stall) begin
      instr_count_d = instr_count_q + 32'd1;
      if (!in_win) begin
        fetch_err_d = 1'b1;
      end
      case (nPC_sel)
        2'b00: pc_d = pc_plus4;
        2'b01: pc_d = zero ? (pc_plus4 + br_off) : pc_plus4;
        2'b10: pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
        2'b11: begin
          // A misaligned jr target is not taken; fall through and flag it.
          if (rs_data[1:0] == 2'b00) begin
            pc_d = rs_data;
          end else begin
            pc_d        = pc_plus4;
            align_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Architectural state with asynchronous reset; memory contents survive reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= PC_BASE;
      instr_count_q <= 32'd0;
      fetch_err_q   <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_count_q <= instr_count_d;
      fetch_err_q   <= fetch_err_d;
      align_err_q   <= align_err_d;
    end
  end

endmodule

// File: tb/tb_mips_ifu.sv
// Bench for mips_ifu: a driver issues directed and random cycles while a
// reference model predicts the post-edge state; a monitor pops predictions
// (and directed probes) from queues and compares them on the falling edge.
module tb_mips_ifu;

  localparam logic [31:0] PB = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, stall, zero, im_we;
  logic [1:0]  nPC_sel;
  logic [31:0] rs_data, im_wdata;
  logic [9:0]  im_waddr;
  logic [31:0] instr, pc, pc_plus4, instr_count;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        fetch_err, align_err;

  mips_ifu #(.ADDR_W(10), .PC_BASE(PB)) dut (
    .clk(clk), .reset(reset), .stall(stall), .nPC_sel(nPC_sel), .zero(zero),
    .rs_data(rs_data), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .instr(instr), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err),
    .align_err(align_err), .instr_count(instr_count)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [31:0] instr;
    logic        ferr;
    logic        aerr;
  } exp_t;

  exp_t        exp_q[$];
  string       dq_name[$];
  logic [31:0] dq_act[$];
  logic [31:0] dq_exp[$];

  int n_err = 0;
  int n_chk = 0;
  int n_txn = 0;

  // Reference model state
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_pc, m_cnt;
  logic        m_ferr, m_aerr;

  function automatic logic inwin(input logic [31:0] a);
    return ({32'd0, a} >= {32'd0, PB}) && ({32'd0, a} <= {32'd0, PB} + 64'd4092);
  endfunction

  function automatic logic [31:0] fetch(input logic [31:0] a);
    if (inwin(a)) return m_mem[10'((a - PB) >> 2)];
    return 32'h0;
  endfunction

  function automatic logic [31:0] gen_word();
    if ($urandom % 2 == 0) return {6'($urandom), 26'h0C00 + 26'($urandom_range(0, 1023))};
    return $urandom;
  endfunction

  function automatic logic [31:0] gen_rs();
    int r;
    r = $urandom % 8;
    if (r < 5) return PB + 32'(4 * $urandom_range(0, 1023));
    if (r == 5) return PB + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
    if (r == 6) return $urandom;
    return PB + 32'h1000 + 32'(4 * $urandom_range(0, 15));
  endfunction

  // Directed probe: queued here, compared by the monitor.
  task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    dq_name.push_back(nm);
    dq_act.push_back(act);
    dq_exp.push_back(expv);
  endtask

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Monitor: drain directed probes, then compare one predicted transaction.
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      while (dq_name.size() > 0) chk(dq_name.pop_front(), dq_act.pop_front(), dq_exp.pop_front());
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: pc=%h count=%h instr=%h ferr=%0b aerr=%0b", n_txn, pc, instr_count, instr, fetch_err, align_err);
        chk("pc", pc, me.pc);
        chk("count", instr_count, me.cnt);
        chk("flags", {30'd0, fetch_err, align_err}, {30'd0, me.ferr, me.aerr});
        chk("instr", instr, me.instr);
        chk("fields", {op, rs, rt, imm16}, me.instr);
        chk("rd_func", {21'd0, rd, func}, {21'd0, me.instr[15:11], me.instr[5:0]});
        chk("pc_plus4", pc_plus4, me.pc + 32'd4);
      end
    end
  end

  // One clock cycle: drive at negedge+1, predict, wait to the next negedge+1.
  task automatic cycle(input logic st, input logic [1:0] ns, input logic z, input logic [31:0] rsd,
                       input logic we, input logic [9:0] wa, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] ins;
    stall = st; nPC_sel = ns; zero = z; rs_data = rsd;
    im_we = we; im_waddr = wa; im_wdata = wd;
    ins = fetch(m_pc);
    #1;
    dchk("pre_edge_instr", instr, ins);
    dchk("pre_edge_pc_plus4", pc_plus4, m_pc + 32'd4);
    if (!st) begin
      if (!inwin(m_pc)) m_ferr = 1'b1;
      case (ns)
        2'd0: m_pc = m_pc + 32'd4;
        2'd1: m_pc = z ? m_pc + 32'd4 + 32'(int'($signed(ins[15:0])) * 4) : m_pc + 32'd4;
        2'd2: m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        default: begin
          if (rsd % 4 == 0) m_pc = rsd;
          else begin
            m_pc = m_pc + 32'd4;
            m_aerr = 1'b1;
          end
        end
      endcase
      m_cnt = m_cnt + 32'd1;
    end
    if (we) m_mem[wa] = wd;
    e.pc = m_pc; e.cnt = m_cnt; e.instr = fetch(m_pc); e.ferr = m_ferr; e.aerr = m_aerr;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = PB; m_cnt = 32'd0; m_ferr = 1'b0; m_aerr = 1'b0;
  endtask

  // Loader write, usable while reset holds the PC.
  task automatic load(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    im_we = 1'b1; im_waddr = a; im_wdata = d;
    @(posedge clk);
    #1;
    im_we = 1'b0;
    m_mem[a] = d;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic reset_assert();
    im_we = 1'b0; stall = 1'b0; nPC_sel = 2'd0;
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    dchk("rst_pc", pc, PB);
    dchk("rst_count", instr_count, 32'd0);
    dchk("rst_flags", {30'd0, fetch_err, align_err}, 32'd0);
  endtask

  task automatic reset_release();
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; nPC_sel = 2'd0; zero = 1'b0; rs_data = 32'd0;
    im_we = 1'b0; im_waddr = 10'd0; im_wdata = 32'd0;
    model_reset();

    // Preload memory during reset, then the sequential program words.
    for (int i = 0; i < 1024; i++) load(10'(i), gen_word());
    load(10'd0, 32'h3401_0005);
    load(10'd1, 32'h0000_0000);
    load(10'd2, 32'h0000_0000);
    dchk("init_pc", pc, 32'h0000_3000);
    dchk("init_count", instr_count, 32'd0);
    dchk("init_flags", {30'd0, fetch_err, align_err}, 32'd0);
    dchk("init_op", {26'd0, op}, 32'h0000_000D);
    reset_release();

    // Sequential
    cycle(0, 2'd0, 0, 32'd0, 0, 10'd0, 32'd0);
    dchk("seq_pc1", pc, 32'h0000_3004);
    cycle(0, 2'd0, 0, 32'd0, 0, 10'd0, 32'd0);
    dchk("seq_pc2", pc, 32'h0000_3008);
    dchk("seq_count", instr_count, 32'd2);

    // beq
    reset_assert();
    load(10'd1, 32'h1000_FFFF);
    reset_release();
    cycle(0, 2'd0, 0, 32'd0, 0, 10'd0, 32'd0);
    cycle(0, 2'd1, 1, 32'd0, 0, 10'd0, 32'd0);
    dchk("beq_back", pc, 32'h0000_3004);
    cycle(0, 2'd1, 0, 32'd0, 0, 10'd0, 32'd0);
    dchk("beq_not_taken", pc, 32'h0000_3008);
    cycle(0, 2'd3, 0, 32'h0000_3004, 0, 10'd0, 32'd0);
    cycle(1, 2'd1, 1, 32'd0, 1, 10'd1, 32'h1000_0003);
    dchk("stall_write", instr, 32'h1000_0003);
    cycle(0, 2'd1, 1, 32'd0, 0, 10'd0, 32'd0);
    dchk("beq_fwd", pc, 32'h0000_3014);

    // jr
    cycle(0, 2'd3, 0, 32'h0000_3010, 0, 10'd0, 32'd0);
    dchk("jr_pc", pc, 32'h0000_3010);
    cycle(0, 2'd3, 0, 32'h0000_3012, 0, 10'd0, 32'd0);
    dchk("jr_misalign_pc", pc, 32'h0000_3014);
    dchk("jr_align_err", {31'd0, align_err}, 32'd1);
    cycle(0, 2'd0, 0, 32'd0, 0, 10'd0, 32'd0);
    dchk("align_sticky", {31'd0, align_err}, 32'd1);

    // Stall freezes everything regardless of nPC_sel
    for (int i = 0; i < 3; i++) cycle(1, 2'($urandom), 1'($urandom), gen_rs(), 0, 10'd0, 32'd0);
    dchk("stall_pc", pc, 32'h0000_3018);
    dchk("stall_count", instr_count, 32'd8);

    // Counter wrap
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    dchk("count_forced", instr_count, 32'hFFFF_FFFF);
    cycle(0, 2'd0, 0, 32'd0, 0, 10'd0, 32'd0);
    dchk("count_wrap", instr_count, 32'd0);

    // j/jal
    reset_assert();
    load(10'd0, 32'h0C00_0C10);
    reset_release();
    dchk("jal_link", pc_plus4, 32'h0000_3004);
    cycle(0, 2'd2, 0, 32'd0, 0, 10'd0, 32'd0);
    dchk("j_target", pc, 32'h0000_3040);
    cycle(1, 2'd0, 0, 32'd0, 1, 10'd0, 32'h3401_0005);

    // Fetch window
    cycle(0, 2'd3, 0, 32'h0000_4000, 0, 10'd0, 32'd0);
    dchk("oow_instr", instr, 32'd0);
    dchk("oow_ferr_before", {31'd0, fetch_err}, 32'd0);
    cycle(0, 2'd0, 0, 32'd0, 0, 10'd0, 32'd0);
    dchk("oow_ferr_after", {31'd0, fetch_err}, 32'd1);

    // Mid-run asynchronous reset keeps memory
    reset_assert();
    dchk("rst_mem0", instr, 32'h3401_0005);
    @(posedge clk);
    reset_release();

    // Random segments separated by mid-cycle resets
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 80; i++) begin
        cycle(($urandom % 4) == 0, 2'($urandom), 1'($urandom), gen_rs(),
              ($urandom % 4) == 0, 10'($urandom), gen_word());
      end
      reset_assert();
      @(posedge clk);
      reset_release();
    end

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
